// File: rtl/arith_div_pkg.sv
// Shared types and helpers for the sequential signed divider and its step cell.
// The FSM encoding and the two's-complement magnitude helper live here.
package arith_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_t;

   // Magnitude of a width-bit two's complement value held in the low bits.
   // The most negative value maps to 2^(width-1), which fits as unsigned.
   function automatic logic [31:0] abs_mag(input logic [31:0] value, input int width);
      logic [31:0] mask;
      logic [31:0] v;
      logic [31:0] sgn;
      mask = (32'h1 << width) - 32'h1;
      v    = value & mask;
      sgn  = value >> (width - 1);
      if (sgn[0])
         abs_mag = (~v + 32'h1) & mask;
      else
         abs_mag = v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the
// divisor magnitude, keep the difference or restore, and shift in the quotient bit.
module div_step #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic [VW-1:0] rem_in,
   input  logic [DW-1:0] quo_in,
   input  logic [VW:0]   dmag,
   output logic [VW-1:0] rem_out,
   output logic [DW-1:0] quo_out
);

   logic [VW:0]   shifted;
   logic [VW+1:0] diff;
   logic          borrow;

   always_comb begin
      shifted = {rem_in, quo_in[DW-1]};
      diff    = {1'b0, shifted} - {1'b0, dmag};
      // A trial that goes negative or would not fit back into VW bits is rejected.
      borrow  = diff[VW+1] | diff[VW];
      rem_out = borrow ? shifted[VW-1:0] : diff[VW-1:0];
      quo_out = {quo_in[DW-2:0], ~borrow};
   end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both operand and result sides.
module seq_signed_divider
   import arith_div_pkg::*;
#(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero,
   output logic          overflow
);

   localparam int CNT_W = $clog2(DW);

   div_state_t        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [VW-1:0]     rem_reg;
   logic [DW-1:0]     quo_reg;
   logic [VW:0]       dmag_reg;
   logic              dvd_neg_reg, dvs_neg_reg, ovf_case_reg;
   logic [DW-1:0]     quotient_reg;
   logic [VW-1:0]     remainder_reg;
   logic              dbz_reg, ovf_reg;

   logic [DW-1:0]     dvd_mag;
   logic [VW:0]       dvs_mag;
   logic              divisor_zero, ovf_case;
   logic [VW-1:0]     step_rem;
   logic [DW-1:0]     step_quo;

   always_comb begin
      dvd_mag      = DW'(abs_mag(32'(dividend), DW));
      dvs_mag      = (VW+1)'(abs_mag(32'(divisor), VW));
      divisor_zero = (divisor == '0);
      ovf_case     = (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
   end

   div_step #(.DW(DW), .VW(VW)) u_step (
      .rem_in  (rem_reg),
      .quo_in  (quo_reg),
      .dmag    (dmag_reg),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (in_valid) state_next = divisor_zero ? DONE : CALC;
         CALC: if (cnt_reg == '0) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (state_reg == IDLE);
      out_valid   = (state_reg == DONE);
      quotient    = quotient_reg;
      remainder   = remainder_reg;
      div_by_zero = dbz_reg;
      overflow    = ovf_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg       <= '0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         dmag_reg      <= '0;
         dvd_neg_reg   <= 1'b0;
         dvs_neg_reg   <= 1'b0;
         ovf_case_reg  <= 1'b0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
         ovf_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (in_valid) begin
               rem_reg      <= '0;
               quo_reg      <= dvd_mag;
               dmag_reg     <= dvs_mag;
               dvd_neg_reg  <= dividend[DW-1];
               dvs_neg_reg  <= divisor[VW-1];
               ovf_case_reg <= ovf_case;
               cnt_reg      <= CNT_W'(DW - 1);
               dbz_reg      <= divisor_zero;
               ovf_reg      <= 1'b0;
               if (divisor_zero) begin
                  quotient_reg  <= '1;
                  remainder_reg <= '0;
               end
            end
            CALC: begin
               rem_reg <= step_rem;
               quo_reg <= step_quo;
               if (cnt_reg != '0)
                  cnt_reg <= cnt_reg - 1'b1;
            end
            // Most-negative / -1 wraps naturally: the magnitude 2^(DW-1) reads back as itself.
            FIX: begin
               quotient_reg  <= (dvd_neg_reg ^ dvs_neg_reg) ? -quo_reg : quo_reg;
               remainder_reg <= dvd_neg_reg ? -rem_reg : rem_reg;
               ovf_reg       <= ovf_case_reg;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench: directed corner cases plus randomized signed operands
// compared against plain integer division and modulo.
module tb_seq_signed_divider;

   localparam int DW = 8;
   localparam int VW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;
   logic          overflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_signed_divider #(.DW(DW), .VW(VW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: truncating integer division, remainder takes the dividend's sign.
   task automatic ref_div(input int a, input int b, output logic [DW-1:0] q,
                          output logic [VW-1:0] r, output logic dz, output logic ov);
      int qi;
      int ri;
      if (b == 0) begin
         q = '1; r = '0; dz = 1'b1; ov = 1'b0;
      end else begin
         qi = a / b;
         ri = a % b;
         q  = qi[DW-1:0];
         r  = ri[VW-1:0];
         dz = 1'b0;
         ov = (qi >= (1 << (DW - 1)));
      end
   endtask

   task automatic do_op(input int a, input int b, input int stall, input bit chk_lat);
      logic [DW-1:0] eq;
      logic [VW-1:0] er;
      logic          ed, eo;
      int            cyc;
      ref_div(a, b, eq, er, ed, eo);
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      dividend  = DW'(a);
      divisor   = VW'(b);
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 40) begin
         chk("in_ready_busy", 32'(in_ready), 32'd0);
         @(negedge clk);
         cyc++;
      end
      chk("out_valid", 32'(out_valid), 32'd1);
      if (chk_lat) chk("latency", 32'(cyc), (b == 0) ? 32'd1 : 32'(DW + 2));
      chk("quotient", 32'(quotient), 32'(eq));
      chk("remainder", 32'(remainder), 32'(er));
      chk("div_by_zero", 32'(div_by_zero), 32'(ed));
      chk("overflow", 32'(overflow), 32'(eo));
      chk("in_ready_done", 32'(in_ready), 32'd0);
      $display("op %0d / %0d -> q=%0d r=%0d dz=%b ov=%b lat=%0d stall=%0d",
               a, b, $signed(quotient), $signed(remainder), div_by_zero, overflow, cyc, stall);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_quotient", 32'(quotient), 32'(eq));
         chk("hold_remainder", 32'(remainder), 32'(er));
         chk("hold_flags", 32'({div_by_zero, overflow}), 32'({ed, eo}));
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("out_valid_drop", 32'(out_valid), 32'd0);
      chk("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   initial begin
      int cyc;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
      rst = 1'b0;

      do_op(100, 7, 0, 1);
      do_op(-100, 7, 0, 1);
      do_op(100, -7, 0, 1);
      do_op(-100, -7, 0, 1);
      do_op(-128, -1, 0, 1);
      do_op(-128, -8, 0, 1);
      do_op(5, 0, 0, 1);
      do_op(9, 3, 0, 1);
      do_op(127, 4, 6, 1);
      do_op(-128, 1, 0, 1);
      do_op(7, -8, 0, 1);

      // Reset in the middle of CALC takes effect without waiting for a clock edge.
      @(negedge clk);
      dividend = 8'd77; divisor = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_calc_in_ready", 32'(in_ready), 32'd1);
      chk("rst_calc_out_valid", 32'(out_valid), 32'd0);
      chk("rst_calc_quotient", 32'(quotient), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      do_op(50, -6, 0, 1);

      // Reset while a result is waiting drops out_valid immediately.
      @(negedge clk);
      dividend = 8'd100; divisor = 4'd7; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_done_out_valid", 32'(out_valid), 32'd0);
      chk("rst_done_quotient", 32'(quotient), 32'd0);
      chk("rst_done_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;

      for (int n = 0; n < 1500; n++) begin
         int a;
         int b;
         int st;
         a  = int'($urandom_range(0, 255)) - 128;
         b  = int'($urandom_range(0, 15)) - 8;
         st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
         do_op(a, b, st, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
